// File: rtl/sprite_frame_buffer.sv
// Double-buffered 64x32x3 frame store feeding the HUB75 scan driver.
// Renders the 11x8 monster sprite into the back buffer and swaps on a frame boundary.
module sprite_frame_buffer #(
  parameter int SPR_W = 11,
  parameter int SPR_H = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       draw_start,
  input  logic [5:0] sprite_x,
  input  logic [4:0] sprite_y,
  input  logic [2:0] sprite_color,
  input  logic       frame_sync,
  input  logic [3:0] rd_row,
  input  logic [5:0] rd_col,
  output logic [2:0] rgb0,
  output logic [2:0] rgb1,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    DRAW      = 3'd2,
    WAIT_SYNC = 3'd3,
    SWAP      = 3'd4
  } state_t;

  state_t state, state_nx;

  logic       front_sel;
  logic       frame_valid;
  logic [4:0] clr_cnt;
  logic [2:0] spr_r;
  logic [3:0] spr_c;
  logic [5:0] lat_x;
  logic [4:0] lat_y;
  logic [2:0] lat_color;

  // Each row holds 64 pixels of 3 bits, so a whole-row clear is a single write.
  logic [191:0] mem0 [32];
  logic [191:0] mem1 [32];

  function automatic logic [10:0] bitmap_row(input logic [2:0] r);
    case (r)
      3'd0:    bitmap_row = 11'h088;
      3'd1:    bitmap_row = 11'h088;
      3'd2:    bitmap_row = 11'h050;
      3'd3:    bitmap_row = 11'h0F8;
      3'd4:    bitmap_row = 11'h1AC;
      3'd5:    bitmap_row = 11'h1FC;
      3'd6:    bitmap_row = 11'h2FA;
      default: bitmap_row = 11'h489;
    endcase
  endfunction

  logic        last_px;
  assign last_px = (spr_r == 3'(SPR_H - 1)) && (spr_c == 4'(SPR_W - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (draw_start) state_nx = CLEAR;
      CLEAR:     if (clr_cnt == 5'd31) state_nx = DRAW;
      DRAW:      if (last_px) state_nx = WAIT_SYNC;
      WAIT_SYNC: if (frame_sync) state_nx = SWAP;
      SWAP:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == SWAP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      front_sel   <= 1'b0;
      frame_valid <= 1'b0;
      clr_cnt     <= '0;
      spr_r       <= '0;
      spr_c       <= '0;
      lat_x       <= '0;
      lat_y       <= '0;
      lat_color   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          clr_cnt <= '0;
          spr_r   <= '0;
          spr_c   <= '0;
          if (draw_start) begin
            lat_x     <= sprite_x;
            lat_y     <= sprite_y;
            lat_color <= sprite_color;
          end
        end
        CLEAR: clr_cnt <= clr_cnt + 5'd1;
        DRAW: begin
          if (spr_c == 4'(SPR_W - 1)) begin
            spr_c <= '0;
            spr_r <= spr_r + 3'd1;
          end else begin
            spr_c <= spr_c + 4'd1;
          end
        end
        SWAP: begin
          front_sel   <= ~front_sel;
          frame_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sums are one bit wider than the screen so off-screen pixels clip instead of wrapping.
  logic [6:0]  px_x;
  logic [5:0]  px_y;
  logic [10:0] bm_row;
  logic        row_we;
  logic        pix_we;
  logic [4:0]  wr_row;
  logic [7:0]  wr_bit;

  always_comb begin
    px_x   = {1'b0, lat_x} + {3'b000, spr_c};
    px_y   = {1'b0, lat_y} + {3'b000, spr_r};
    bm_row = bitmap_row(spr_r);
    row_we = rst && (state == CLEAR);
    pix_we = rst && (state == DRAW) && bm_row[spr_c] && !px_x[6] && !px_y[5];
    wr_row = row_we ? clr_cnt : px_y[4:0];
    wr_bit = 8'(px_x[5:0]) * 8'd3;
  end

  always_ff @(posedge clk) begin
    if (front_sel) begin
      if (row_we)      mem0[wr_row] <= '0;
      else if (pix_we) mem0[wr_row][wr_bit +: 3] <= lat_color;
    end else begin
      if (row_we)      mem1[wr_row] <= '0;
      else if (pix_we) mem1[wr_row][wr_bit +: 3] <= lat_color;
    end
  end

  // During SWAP the read already targets the incoming front so the first post-swap read is new.
  logic       rd_sel;
  logic       rd_ok;
  logic [7:0] rd_bit;
  logic [4:0] rd_lo;
  logic [4:0] rd_hi;

  always_comb begin
    rd_sel = (state == SWAP) ? ~front_sel : front_sel;
    rd_ok  = frame_valid || (state == SWAP);
    rd_bit = 8'(rd_col) * 8'd3;
    rd_lo  = {1'b0, rd_row};
    rd_hi  = {1'b1, rd_row};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rgb0 <= '0;
      rgb1 <= '0;
    end else if (!rd_ok) begin
      rgb0 <= '0;
      rgb1 <= '0;
    end else if (rd_sel) begin
      rgb0 <= mem1[rd_lo][rd_bit +: 3];
      rgb1 <= mem1[rd_hi][rd_bit +: 3];
    end else begin
      rgb0 <= mem0[rd_lo][rd_bit +: 3];
      rgb1 <= mem0[rd_hi][rd_bit +: 3];
    end
  end

endmodule
